// File: rtl/mux_pipe_pkg.sv
// Shared constants, output-stage state encoding and a ceiling-log2 helper
// for the NUM_IN:1 registered mux.
package mux_pipe_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_NUM_IN    = 4;
  localparam int DEF_SEL_W     = 2;
  localparam int DEF_ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  // Smallest r with 2**r >= n; the select must be at least this wide.
  function automatic int clog2_int(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nbit_mux_n_one.sv
// Combinational WIDTH-bit NUM_IN:1 selector; an out-of-range select yields
// a zero word and raises bad.
module nbit_mux_n_one
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    bad
);

  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

  always_comb begin
    word = '0;
    bad  = ({1'b0, sel} >= NUM_IN_L);
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        word = data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/nbit_mux_n_one_pipe.sv
// Registered NUM_IN:1 mux behind a valid/ready handshake with a saturating
// bad-select counter. Define MUX_PIPE_SKID_EN for a one-entry skid buffer.
//
// state    | meaning
// ST_EMPTY | output register empty, out_valid=0
// ST_FULL  | output register holds a word
// ST_SKID  | output full and stalled, skid holds the next word (skid build)
module nbit_mux_n_one_pipe
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_IN    = DEF_NUM_IN,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_bad_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  generate
    if (NUM_IN < 2 || NUM_IN > 16 || SEL_W < clog2_int(NUM_IN)) begin : g_param_err
      $error("nbit_mux_n_one_pipe: NUM_IN must be 2..16 and SEL_W >= clog2(NUM_IN)");
    end
  endgenerate

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  pipe_state_e       state;
  pipe_state_e       state_nxt;
  logic [WIDTH-1:0]  sel_word;
  logic              sel_bad;
  logic              accept;
  logic              load_out;
  logic              load_reg;
  logic [WIDTH-1:0]  nxt_data;
  logic              nxt_bad;

  nbit_mux_n_one #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_sel (
    .data(in_data),
    .sel (in_sel),
    .word(sel_word),
    .bad (sel_bad)
  );

  assign accept    = in_valid && in_ready;
  assign out_valid = (state != ST_EMPTY);

`ifdef MUX_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_data;
  logic             skid_bad;
  logic             load_skid;
  logic             load_from_skid;
  logic             ready_q;

  // Registered ready: out_ready never reaches in_ready combinationally.
  assign in_ready = ready_q;

  always_comb begin
    state_nxt      = state;
    load_out       = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_FULL;
          load_out  = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (accept) load_out = 1'b1;
          else        state_nxt = ST_EMPTY;
        end else if (accept) begin
          state_nxt = ST_SKID;
          load_skid = 1'b1;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          state_nxt      = ST_FULL;
          load_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data <= '0;
      skid_bad  <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      if (load_skid) begin
        skid_data <= sel_word;
        skid_bad  <= sel_bad;
      end
      ready_q <= (state_nxt != ST_SKID);
    end
  end

  // The skid entry drains ahead of any new input to keep order.
  assign load_reg = load_out || load_from_skid;
  assign nxt_data = load_from_skid ? skid_data : sel_word;
  assign nxt_bad  = load_from_skid ? skid_bad  : sel_bad;
`else
  assign in_ready = !out_valid || out_ready;

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_FULL;
          load_out  = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (accept) load_out = 1'b1;
          else        state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  assign load_reg = load_out;
  assign nxt_data = sel_word;
  assign nxt_bad  = sel_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_bad_sel <= 1'b0;
    end else if (load_reg) begin
      out_data    <= nxt_data;
      out_bad_sel <= nxt_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && sel_bad && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nbit_mux_n_one_pipe.sv
// Directed bench: a default 4-input instance and a 3-input instance with a
// 2-bit error counter; expectations adapt when MUX_PIPE_SKID_EN is defined.
module tb_nbit_mux_n_one_pipe;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4*W-1:0] a_in_data;
  logic [1:0]     a_in_sel;
  logic           a_in_valid, a_in_ready, a_out_bad_sel, a_out_valid, a_out_ready;
  logic [W-1:0]   a_out_data;
  logic [7:0]     a_err_cnt;

  logic [3*W-1:0] b_in_data;
  logic [1:0]     b_in_sel;
  logic           b_in_valid, b_in_ready, b_out_bad_sel, b_out_valid, b_out_ready;
  logic [W-1:0]   b_out_data;
  logic [1:0]     b_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  nbit_mux_n_one_pipe dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_bad_sel(a_out_bad_sel), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .err_cnt(a_err_cnt)
  );

  nbit_mux_n_one_pipe #(.WIDTH(W), .NUM_IN(3), .SEL_W(2), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_bad_sel(b_out_bad_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .err_cnt(b_err_cnt)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    b_in_data = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    a_in_sel = 2'd0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_sel = 2'd0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    #2;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
    n_cmp++; if (a_out_bad_sel !== 1'b0) begin n_bad++; $display("FAIL reset_bad_sel: got %b want 0", a_out_bad_sel); end
    n_cmp++; if (a_err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", a_err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
  endtask

  task automatic test_streaming();
    logic [W-1:0] exp_data [4];
    exp_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_sel = 2'(i);
      a_in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, a_out_valid); end
      n_cmp++; if (a_out_data !== exp_data[i]) begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, a_out_data, exp_data[i]); end
    end
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain: got %b want 0", a_out_valid); end
  endtask

  task automatic test_stall();
    logic exp_rdy;
    a_out_ready = 1'b0;
    a_in_sel = 2'd2;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (a_out_data !== 32'h33333333) begin n_bad++; $display("FAIL stall_load: got %h want 33333333", a_out_data); end
    a_in_sel = 2'd3;
    #1;
`ifdef MUX_PIPE_SKID_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    n_cmp++; if (a_in_ready !== exp_rdy) begin n_bad++; $display("FAIL stall_first_ready: got %b want %b", a_in_ready, exp_rdy); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (a_out_data !== 32'h33333333) begin n_bad++; $display("FAIL stall_hold[%0d]: got %h want 33333333", k, a_out_data); end
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_bad_sel !== 1'b0) begin n_bad++; $display("FAIL stall_flags[%0d]: got v=%b b=%b want v=1 b=0", k, a_out_valid, a_out_bad_sel); end
      n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0", k, a_in_ready); end
    end
    a_out_ready = 1'b1;
`ifdef MUX_PIPE_SKID_EN
    a_in_valid = 1'b0;
`endif
    @(posedge clk); #1;
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h44444444) begin n_bad++; $display("FAIL stall_second_word: got v=%b %h want v=1 44444444", a_out_valid, a_out_data); end
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drain: got %b want 0", a_out_valid); end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] exp_data [3];
    exp_data = '{32'h11111111, 32'h22222222, 32'h33333333};
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_sel = 2'(i);
      @(posedge clk); #1;
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== exp_data[i]) begin n_bad++; $display("FAIL simul_word[%0d]: got v=%b %h want v=1 %h", i, a_out_valid, a_out_data, exp_data[i]); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL simul_ready[%0d]: got %b want 1", i, a_in_ready); end
    end
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL simul_drain: got %b want 0", a_out_valid); end
  endtask

  task automatic test_bad_sel();
    b_out_ready = 1'b1;
    b_in_sel = 2'd3;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (b_out_data !== 32'h0 || b_out_bad_sel !== 1'b1) begin n_bad++; $display("FAIL bad_sel_word: got %h b=%b want 0 b=1", b_out_data, b_out_bad_sel); end
    n_cmp++; if (b_err_cnt !== 2'd1) begin n_bad++; $display("FAIL bad_sel_cnt: got %0d want 1", b_err_cnt); end
    b_in_sel = 2'd0;
    @(posedge clk); #1;
    n_cmp++; if (b_out_data !== 32'hAAAAAAAA || b_out_bad_sel !== 1'b0) begin n_bad++; $display("FAIL bad_sel_recover: got %h b=%b want AAAAAAAA b=0", b_out_data, b_out_bad_sel); end
    b_in_sel = 2'd2;
    @(posedge clk); #1;
    n_cmp++; if (b_out_data !== 32'hCCCCCCCC || b_err_cnt !== 2'd1) begin n_bad++; $display("FAIL bad_sel_top: got %h cnt=%0d want CCCCCCCC cnt=1", b_out_data, b_err_cnt); end
    b_in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [4];
    exp_cnt = '{2'd2, 2'd3, 2'd3, 2'd3};
    b_in_sel = 2'd3;
    b_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (b_err_cnt !== exp_cnt[k]) begin n_bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, b_err_cnt, exp_cnt[k]); end
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    a_out_ready = 1'b0;
    a_in_sel = 2'd1;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_sel = 2'd2;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h22222222) begin n_bad++; $display("FAIL rst_pre_full: got v=%b %h want v=1 22222222", a_out_valid, a_out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h0) begin n_bad++; $display("FAIL rst_async_out: got v=%b %h want v=0 0", a_out_valid, a_out_data); end
    n_cmp++; if (b_err_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_async_cnt: got %0d want 0", b_err_cnt); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_async_ready: got %b want 1", a_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    a_in_sel = 2'd0;
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h11111111) begin n_bad++; $display("FAIL rst_after_word: got v=%b %h want v=1 11111111", a_out_valid, a_out_data); end
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_stale: got %b want 0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_simultaneous();
    test_bad_sel();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
